bit_serializer: RTL
===================

# bit_serializer

Parallel-to-serial stage feeding the sequence-detector FSM. It accepts a word over a valid/ready handshake and shifts it out one bit at a time on `bit_out`, which drives the detector's serial `in`. Each bit is held for a programmable number of clock cycles, and a one-cycle `bit_valid` strobe marks the first cycle of every bit. The detector's `in` can be driven directly, or gated by `bit_valid` when the detector clock is enabled per bit.

## Interface
- `DATA_W`, default 8: word width in bits; must be at least 2.
- `DIV_W`, default 8: width of the bit-period divider input.
- `clk  input  1`: single clock; all state updates on the rising edge.
- `reset  input  1`: asynchronous, active-high reset.
- `din  input  DATA_W`: word to serialize; sampled on accept.
- `din_valid  input  1`: upstream has a word on `din`.
- `din_ready  output  1`: block can accept a word this cycle.
- `div  input  DIV_W`: bit period is `div+1` cycles; sampled on accept.
- `bit_out  output  1`: current serial bit.
- `bit_valid  output  1`: high only in the first cycle of each bit period.
- `busy  output  1`: a word is being shifted.

## Operation
- States:
  - IDLE: `busy=0`, `bit_out=0`, `bit_valid=0`.
  - SHIFT: `busy=1`.
- Internal registers:
  - `shreg[DATA_W-1:0]`
  - `bitcnt`, width `clog2(DATA_W)`: bits already completed.
  - `percnt[DIV_W-1:0]`: cycles elapsed in current bit.
  - `divreg[DIV_W-1:0]`
- Accept condition: `din_valid && din_ready` at a rising edge. On accept:
  - `shreg <= din`, `divreg <= div`, `bitcnt <= 0`, `percnt <= 0`.
  - State goes to SHIFT.
- `din_ready` (combinational):
  - High in IDLE.
  - High in SHIFT only when `bitcnt == DATA_W-1` and `percnt == divreg`, i.e. the last cycle of the last bit.
- In SHIFT, each cycle:
  - If `percnt != divreg`: `percnt <= percnt+1`.
  - Otherwise `percnt <= 0`, the register shifts (LSB-first: right shift, 0 fill), and `bitcnt <= bitcnt+1`.
- `bit_out` is `shreg[0]` in SHIFT (LSB-first) and 0 in IDLE.
- `bit_valid` is `busy && percnt == 0`.
- End of word (last cycle of last bit):
  - With an accept: reload and stay in SHIFT. There are no idle cycles between words.
  - Without an accept: go to IDLE.
- `din` and `div` changes while not accepting are ignored. `divreg` is fixed for the whole word.
- `div` = all-ones is legal: period is `2^DIV_W` cycles. No wrap occurs because `percnt` resets on reaching `divreg`.
- `din_valid` low in IDLE: outputs stay at their idle values indefinitely.

## Timing
- Reset values, asserted immediately (asynchronous): `din_ready=1`, `busy=0`, `bit_out=0`, `bit_valid=0`. All registers are cleared and the state is IDLE.
- Reset mid-word: the word is dropped. The first edge after deassertion can accept a new word.
- Accept at edge T → bit 0 appears on `bit_out` with `bit_valid=1` in cycle T+1 (latency 1).
- Bit k occupies cycles T+1+k·(div+1) through T+(k+1)·(div+1).
- One word lasts exactly `DATA_W·(div+1)` cycles.
- Sustained throughput is 1 word per `DATA_W·(div+1)` cycles when `din_valid` is held high.
- `div=0`: `bit_valid` is continuously high while busy and `din_ready` is high every DATA_W-th cycle.

## Configuration
- `BIT_SERIALIZER_MSB_FIRST_EN`
  - Defined: shifting is left with 0 fill, and `bit_out = shreg[DATA_W-1]`, so the MSB is sent first.
  - Undefined (default): LSB-first as above.
  - Handshake, timing, and reset behaviour are identical in both builds.

## Test plan
- Reset then idle:
  - During and after reset, `din_ready=1`, `busy=0`, `bit_out=0`, `bit_valid=0`.
  - Nothing changes with `din_valid=0` for 20 cycles.
- `din=8'hA5`, `div=0`, single accept:
  - `bit_out` = 1,0,1,0,0,1,0,1 on cycles T+1..T+8 with `bit_valid=1` on each.
  - IDLE at T+9.
- `din=8'h3C`, `div=2`:
  - Each bit is held 3 cycles, `bit_valid` pulses at T+1, T+4, …, T+22.
  - `din_ready` rises only at T+24. `div` changed to 5 mid-word has no effect.
- Back-to-back `8'h00` then `8'hFF`, `div=0`, `din_valid` held high:
  - 16 consecutive cycles of `bit_valid=1` with `bit_out` = eight 0s then eight 1s.
  - `din_ready=1` only at T and T+8.
  - When wired to the detector, its `out` is high from the 4th zero onward and again from the 4th one onward.
- Reset asserted at T+4 of a `div=0` word:
  - Outputs return to reset values immediately.
  - After release, `8'h01` is accepted and serialized correctly from bit 0.
- With `BIT_SERIALIZER_MSB_FIRST_EN` and `din=8'hA5`, `div=0`: `bit_out` = 1,0,1,0,0,1,0,1 reversed order of bits, i.e. bits 7..0 = 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts a word on valid/ready and shifts it out
// one bit per (div+1) cycles. Define BIT_SERIALIZER_MSB_FIRST_EN for MSB-first order.
module bit_serializer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DIV_W-1:0]  div,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q,  state_d;
  logic [DATA_W-1:0]  shreg_q,  shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]   percnt_q, percnt_d;
  logic [DIV_W-1:0]   divreg_q, divreg_d;

  logic period_end;
  logic word_end;
  logic accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      percnt_q <= '0;
      divreg_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      percnt_q <= percnt_d;
      divreg_q <= divreg_d;
    end
  end

  assign period_end = (percnt_q == divreg_q);
  assign word_end   = (state_q == SHIFT) && period_end &&
                      (bitcnt_q == CNT_W'(DATA_W - 1));
  assign accept     = din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    percnt_d = percnt_q;
    divreg_d = divreg_q;
    if (accept) begin
      // Reload takes priority over end-of-word so consecutive words leave no gap.
      state_d  = SHIFT;
      shreg_d  = din;
      divreg_d = div;
      bitcnt_d = '0;
      percnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (!period_end) begin
        percnt_d = percnt_q + DIV_W'(1);
      end else begin
        percnt_d = '0;
        bitcnt_d = bitcnt_q + CNT_W'(1);
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
`else
        shreg_d  = {1'b0, shreg_q[DATA_W-1:1]};
`endif
        if (word_end) begin
          state_d  = IDLE;
          bitcnt_d = '0;
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    din_ready = (state_q == IDLE) || word_end;
    bit_valid = busy && (percnt_q == '0);
    bit_out   = 1'b0;
    if (busy) begin
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      bit_out = shreg_q[DATA_W-1];
`else
      bit_out = shreg_q[0];
`endif
    end
  end

endmodule
